// File: rtl/posit_add_issue_es3.sv
// rtl/posit_add_issue_es3.sv - issue-side controller for the pipelined es3 posit adder
//
// Accepts operand pairs on an upstream valid/ready stream, issues them to a
// fixed-latency adder over its start/done interface, captures each result in a
// FIFO and presents the FIFO head downstream on a valid/ready stream.
// Credit-based flow control: an operand is only accepted while the number of
// issued-but-not-popped operations is below DEPTH, so every result that comes
// back from the adder has a FIFO slot waiting for it.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   op_valid/op_ready     upstream operand handshake, op_a/op_b operands
//   add_in1/add_in2       operands to the adder (combinational pass-through)
//   add_start             issue strobe to the adder
//   add_result/inf/zero   adder result and flags, qualified by add_done
//   res_valid/res_ready   downstream result handshake
//   res_data/inf/zero     FIFO head (driven to 0 while the FIFO is empty)
//   outstanding           issued operations not yet popped
//   err                   sticky: unexpected done, or done into a full FIFO

module posit_add_issue_es3 #(
    parameter int NBITS = 32,
    parameter int LAT   = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [NBITS-1:0]           op_a,
    input  logic [NBITS-1:0]           op_b,
    output logic [NBITS-1:0]           add_in1,
    output logic [NBITS-1:0]           add_in2,
    output logic                       add_start,
    input  logic [NBITS-1:0]           add_result,
    input  logic                       add_inf,
    input  logic                       add_zero,
    input  logic                       add_done,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [NBITS-1:0]           res_data,
    output logic                       res_inf,
    output logic                       res_zero,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(LAT + 1);
    localparam int EW = NBITS + 2;

    localparam logic [DW-1:0] DRAIN_START = DW'(LAT);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    rptr_q, rptr_d;
    logic             err_q, err_d;
    logic [EW-1:0]    mem_q [DEPTH];

    logic             run;
    logic             issue;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             done_seen;
    logic             wr_en;
    logic [EW-1:0]    head;

    // ------------------------------------------------------------------
    // Control FSM: after reset the adder pipeline still holds stale work,
    // so nothing is issued and every done is ignored until LAT cycles of
    // drain have flushed all of its stages.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_START;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
    end

    assign run = (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // Issue path. op_ready looks only at registered state, so a pop in
    // the current cycle frees a credit for the next cycle, not this one.
    // ------------------------------------------------------------------
    assign op_ready  = run && (credits_q != '0);
    assign issue     = op_valid && op_ready;
    assign add_in1   = op_a;
    assign add_in2   = op_b;
    assign add_start = issue;

    // ------------------------------------------------------------------
    // Result FIFO. Pointers carry one extra wrap bit so that full and
    // empty are distinguishable when the index bits match.
    // ------------------------------------------------------------------
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign res_valid  = !fifo_empty;
    assign pop        = res_valid && res_ready;

    // A done is only legitimate while something is in flight; a full FIFO
    // may still take it when the head leaves in the same cycle.
    assign done_seen = run && add_done;
    assign wr_en     = done_seen && (inflight_q != '0) && (!fifo_full || pop);

    assign head     = mem_q[rptr_q[AW-1:0]];
    assign res_data = res_valid ? head[NBITS-1:0] : '0;
    assign res_zero = res_valid ? head[NBITS]     : 1'b0;
    assign res_inf  = res_valid ? head[NBITS+1]   : 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= {add_inf, add_zero, add_result};
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_comb begin
        credits_d = credits_q;
        case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, wr_en})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    assign err_d = err_q || (done_seen && !wr_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q  <= DEPTH_C;
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    assign outstanding = DEPTH_C - credits_q;
    assign err         = err_q;

endmodule

// File: tb/tb_posit_add_issue_es3.sv
// tb/tb_posit_add_issue_es3.sv - self-checking bench for posit_add_issue_es3

module tb_posit_add_issue_es3;

    localparam int NBITS = 32;
    localparam int LAT   = 8;
    localparam int DEPTH = 16;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   op_valid;
    logic                   op_ready;
    logic [NBITS-1:0]       op_a, op_b;
    logic [NBITS-1:0]       add_in1, add_in2;
    logic                   add_start;
    logic [NBITS-1:0]       add_result;
    logic                   add_inf, add_zero, add_done;
    logic                   res_valid;
    logic                   res_ready;
    logic [NBITS-1:0]       res_data;
    logic                   res_inf, res_zero;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   err;
    logic                   force_done;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    posit_add_issue_es3 #(.NBITS(NBITS), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
        .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_inf(res_inf), .res_zero(res_zero), .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- posit<32,3> arithmetic from first principles ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real p_dec(input logic [31:0] p);
        logic [31:0] u;
        logic        r;
        int          i, m, k, e;
        real         f, w;
        if (p == 32'h0) return 0.0;
        u = p[31] ? -p : p;
        r = u[30];
        m = 0;
        i = 30;
        while (i >= 0 && u[i] == r) begin m++; i--; end
        k = r ? m - 1 : -m;
        i--;
        e = 0;
        for (int j = 0; j < 3; j++) begin
            e = e * 2;
            if (i >= 0) begin e = e + int'(u[i]); i--; end
        end
        f = 1.0;
        w = 0.5;
        while (i >= 0) begin
            if (u[i]) f = f + w;
            w = w / 2.0;
            i--;
        end
        f = f * pow2(8 * k + e);
        return p[31] ? -f : f;
    endfunction

    function automatic logic [31:0] p_enc(input real v);
        logic [127:0] body;
        logic [30:0]  mant;
        logic [31:0]  res;
        logic [63:0]  frac;
        logic [2:0]   eb;
        real          a;
        int           sc, k, pos;
        if (v == 0.0) return 32'h0;
        a  = (v < 0.0) ? -v : v;
        sc = 0;
        while (a >= 2.0) begin a = a / 2.0; sc++; end
        while (a < 1.0)  begin a = a * 2.0; sc--; end
        if (sc >= 240) begin
            mant = '1;
        end else if (sc < -240) begin
            mant = 31'd1;
        end else begin
            k    = sc >>> 3;
            eb   = 3'(sc - 8 * k);
            body = '0;
            pos  = 127;
            if (k >= 0) begin
                for (int j = 0; j <= k; j++) begin body[pos] = 1'b1; pos--; end
                body[pos] = 1'b0; pos--;
            end else begin
                for (int j = 0; j < -k; j++) begin body[pos] = 1'b0; pos--; end
                body[pos] = 1'b1; pos--;
            end
            for (int j = 2; j >= 0; j--) begin body[pos] = eb[j]; pos--; end
            frac = 64'(longint'((a - 1.0) * pow2(60)));
            for (int j = 59; j >= 0; j--) begin body[pos] = frac[j]; pos--; end
            mant = body[127:97];
            if (body[96] && ((|body[95:0]) || mant[0])) mant = mant + 31'd1;
        end
        res = {1'b0, mant};
        return (v < 0.0) ? -res : res;
    endfunction

    function automatic logic [31:0] posit_add(input logic [31:0] a, input logic [31:0] b);
        if (a == NAR || b == NAR) return NAR;
        return p_enc(p_dec(a) + p_dec(b));
    endfunction

    // ---------------- adder model: fixed latency, never reset ----------------
    logic [LAT-1:0] pv = '0;
    logic [31:0]    pd [LAT];

    always @(posedge clk) begin
        pv[0] <= add_start;
        pd[0] <= posit_add(add_in1, add_in2);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign add_done   = pv[LAT-1] | force_done;
    assign add_result = pd[LAT-1];
    assign add_inf    = (pd[LAT-1] == NAR);
    assign add_zero   = (pd[LAT-1] == 32'h0);

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        inf;
        logic        zero;
        int          rdy;
    } exp_t;

    exp_t q[$];
    int   since_rst = 0;
    bit   started   = 0;
    bit   err_exp   = 0;

    // Transaction-level model: every accepted pair owes exactly one result,
    // visible LAT+1 cycles later, in order; acceptance needs the drain window
    // to be over and fewer than DEPTH results owed.
    always @(negedge clk) begin
        bit   exp_valid, exp_ready;
        exp_t e;
        exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_ready = (since_rst >= LAT + 2) && (q.size() < DEPTH);
        if (started) begin
            chk("op_ready",    64'(op_ready),    64'(exp_ready));
            chk("outstanding", 64'(outstanding), 64'(q.size()));
            chk("res_valid",   64'(res_valid),   64'(exp_valid));
            chk("err",         64'(err),         64'(err_exp));
            if (exp_valid && res_ready) begin
                chk("res_data", 64'(res_data), 64'(q[0].d));
                chk("res_inf",  64'(res_inf),  64'(q[0].inf));
                chk("res_zero", 64'(res_zero), 64'(q[0].zero));
            end
            if (since_rst == 1) begin
                chk("rst_res_bits", 64'({res_inf, res_zero, res_data}), 64'h0);
                chk("rst_add_start", 64'(add_start), 64'h0);
            end
        end
        if (reset) begin
            q.delete();
            since_rst = 1;
            err_exp   = 0;
            started   = 1;
        end else if (started) begin
            if (force_done && since_rst >= LAT + 2) err_exp = 1;
            if (exp_valid && res_ready) void'(q.pop_front());
            if (op_valid && exp_ready) begin
                e.d    = posit_add(op_a, op_b);
                e.inf  = (e.d == NAR);
                e.zero = (e.d == 32'h0);
                e.rdy  = cyc + LAT + 1;
                q.push_back(e);
            end
            if (since_rst < 100000) since_rst++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input logic [31:0] a, input logic [31:0] b, output int n);
        int w = 0;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        while (!op_ready && w < 50) begin tick(); w++; end
        if (!op_ready) chk("issue_timeout", 64'(0), 64'(1));
        n = cyc;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_ready_after_reset(input string name);
        int t0 = cyc;
        while (!op_ready && cyc - t0 < 40) tick();
        chk(name, 64'(cyc - t0), 64'(LAT + 1));
    endtask

    typedef struct {
        logic [31:0] a, b, d;
        logic        inf, zero;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n, w, acc;
        logic bp_ok;

        tbl[0] = '{32'h4000_0000, 32'h4000_0000, 32'h4400_0000, 1'b0, 1'b0};
        tbl[1] = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, 1'b0};
        tbl[2] = '{32'h4400_0000, 32'h4400_0000, 32'h4800_0000, 1'b0, 1'b0};
        tbl[3] = '{32'h4000_0000, 32'h4400_0000, 32'h4600_0000, 1'b0, 1'b0};
        tbl[4] = '{32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[5] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'hC000_0000, 32'hC000_0000, 32'hBC00_0000, 1'b0, 1'b0};

        reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0; force_done = 1'b0;
        op_a = '0; op_b = '0;
        tick(); tick();
        reset = 1'b0;
        wait_ready_after_reset("ready_after_reset");

        // single ops from the table: latency, value, outstanding before pop
        for (int i = 0; i < 7; i++) begin
            issue_one(tbl[i].a, tbl[i].b, n);
            w = 0;
            while (!res_valid && w < 50) begin tick(); w++; end
            chk("latency", 64'(cyc - n), 64'(LAT + 1));
            chk("tbl_data", 64'(res_data), 64'(tbl[i].d));
            chk("tbl_inf",  64'(res_inf),  64'(tbl[i].inf));
            chk("tbl_zero", 64'(res_zero), 64'(tbl[i].zero));
            chk("tbl_outstanding", 64'(outstanding), 64'(1));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            tick();
        end

        // zero then NaR back-to-back, popped later
        op_valid = 1'b1; op_a = 32'h0; op_b = 32'h0;
        tick();
        op_a = NAR; op_b = 32'h4000_0000;
        tick();
        op_valid = 1'b0;
        repeat (LAT + 2) tick();
        chk("zn_first_data", 64'({res_zero, res_inf, res_data}), {30'h0, 2'b10, 32'h0});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("zn_second_data", 64'({res_zero, res_inf, res_data}), {30'h0, 2'b01, NAR});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();

        // backpressure: 20 offers, 16 credits
        acc = 0;
        bp_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op_valid = 1'b1;
            op_a = $urandom;
            op_b = $urandom;
            if (i >= 16 && op_ready) bp_ok = 1'b0;
            if (op_ready) acc++;
            tick();
        end
        op_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'(16));
        chk("bp_ready_low_17th", 64'(bp_ok), 64'(1));
        repeat (LAT + 2) tick();
        chk("bp_outstanding", 64'(outstanding), 64'(16));
        res_ready = 1'b1;
        chk("bp_ready_pop_cycle", 64'(op_ready), 64'(0));
        tick();
        res_ready = 1'b0;
        chk("bp_ready_after_pop", 64'(op_ready), 64'(1));
        res_ready = 1'b1;
        w = 0;
        while (outstanding != 0 && w < 100) begin tick(); w++; end
        chk("bp_drained", 64'(outstanding), 64'(0));
        tick();

        // streaming: issue and pop every cycle
        acc = 0;
        w = 0;
        while (acc < 100 && w < 1000) begin
            op_valid = 1'b1;
            op_a = $urandom;
            op_b = $urandom;
            if (op_ready) acc++;
            tick();
            w++;
        end
        op_valid = 1'b0;
        chk("stream_count", 64'(acc), 64'(100));
        w = 0;
        while (outstanding != 0 && w < 100) begin tick(); w++; end
        chk("stream_drained", 64'(outstanding), 64'(0));
        res_ready = 1'b0;
        tick();

        // reset while three ops are in flight
        op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a = $urandom;
            op_b = $urandom;
            tick();
        end
        op_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready_after_reset("ready_after_midreset");
        repeat (LAT + 4) tick();
        chk("midreset_err", 64'(err), 64'(0));
        chk("midreset_valid", 64'(res_valid), 64'(0));

        // spurious done with nothing in flight
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        chk("spur_err", 64'(err), 64'(1));
        chk("spur_fifo", 64'({res_valid, outstanding}), 64'(0));
        repeat (4) tick();
        chk("spur_err_sticky", 64'(err), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_cleared", 64'(err), 64'(0));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/posit_add_issue_es3.md
# posit_add_issue_es3

Issue-side controller for the pipelined es3 posit adder. It is the initiator on the adder's `start`/`done` interface. It accepts operand pairs from an upstream valid/ready stream and drives the adder's `in1`/`in2`/`start` lines. It captures each `done`-qualified result into a result FIFO and presents results downstream on a valid/ready stream. Because the adder has no backpressure and a fixed latency, this block uses credit-based flow control so that no result is ever dropped.

## Interface
Parameters:
- `NBITS`, 32: posit word width; must match the adder.
- `LAT`, 8: adder latency in cycles, from `start` sampled high to `done` high.
- `DEPTH`, 16: result FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  an operand pair is offered.
- `op_ready`  out  1  the block accepts the pair this cycle.
- `op_a`, `op_b`  in  NBITS  operand posits.
- `add_in1`, `add_in2`  out  NBITS  to the adder's `in1` and `in2`.
- `add_start`  out  1  to the adder's `start`.
- `add_result`  in  NBITS  from the adder's `result`.
- `add_inf`, `add_zero`  in  1  from the adder's `inf` and `zero`.
- `add_done`  in  1  from the adder's `done`.
- `res_valid`  out  1  the FIFO head is valid.
- `res_ready`  in  1  downstream takes the head.
- `res_data`  out  NBITS  head result.
- `res_inf`, `res_zero`  out  1  head flags.
- `outstanding`  out  $clog2(DEPTH)+1  number of issued operations not yet popped.
- `err`  out  1  sticky: `done` arrived unexpectedly, or arrived while the FIFO was full.

## Operation
- State machine has two states, DRAIN and RUN.
  - `reset` forces DRAIN with `drain_cnt` = LAT.
  - In DRAIN, `drain_cnt` decrements once per cycle. `add_done` is ignored (these are stale results from the un-reset adder) and `op_ready` = 0.
  - When `drain_cnt` = 0 the state goes to RUN on the next edge. RUN persists until `reset`.
- Credits:
  - `credits` resets to DEPTH.
  - It decrements on issue (`op_valid & op_ready`) and increments on pop (`res_valid & res_ready`). Issue and pop in the same cycle leave it unchanged.
  - `outstanding` = DEPTH − `credits`.
- `op_ready` = (state == RUN) & (`credits` != 0). It is combinational from registered state only and does not depend on `op_valid` or on a same-cycle pop.
- Issue path is combinational pass-through: `add_in1` = `op_a`, `add_in2` = `op_b`, `add_start` = `op_valid & op_ready`. The adder registers its own inputs.
- `inflight` counter, width $clog2(DEPTH)+1:
  - +1 on issue, −1 on an accepted `add_done`; both in the same cycle leave it unchanged.
  - Resets to 0.
- FIFO write: in RUN with `add_done` = 1, {`add_inf`, `add_zero`, `add_result`} is written.
  - If `inflight` = 0, or the FIFO is full without a pop in the same cycle, the write is dropped and `err` is set.
  - A full FIFO with a simultaneous pop accepts the write.
- FIFO read:
  - `res_*` reflects the head entry.
  - `res_valid` = not empty.
  - A pop advances the read pointer.
  - Pointers wrap modulo DEPTH, with an extra bit for full/empty detection.
- `err` is cleared only by `reset`.

## Timing
- Reset values: `op_ready` 0, `add_start` 0, `res_valid` 0, `outstanding` 0, `err` 0; `res_data`, `res_inf`, `res_zero` 0; state DRAIN.
- `op_ready` first rises LAT+1 cycles after the cycle in which `reset` is deasserted.
- Latency: an operand accepted in cycle N gives `add_done` in cycle N+LAT and `res_valid` in cycle N+LAT+1, if the FIFO is empty before it. This is 9 cycles with the defaults.
- Throughput is one operation per cycle while credits remain.
- The credit invariant `inflight` + FIFO occupancy ≤ DEPTH guarantees that no write is ever dropped in correct operation.
- Reset mid-operation discards all FIFO contents and all in-flight results. The DRAIN window covers every adder stage.

## Test plan
- Single op: after reset, wait for `op_ready`. Issue `op_a` = 0x40000000, `op_b` = 0x40000000 (1.0 + 1.0) in cycle N. Required: `res_valid` in cycle N+9, `res_data` = 0x44000000, `res_inf` = 0, `res_zero` = 0, `outstanding` = 1 until the pop.
- Zero and NaR: issue 0x00000000 + 0x00000000, then 0x80000000 + 0x40000000, back-to-back. Required: results in order {0x00000000, zero = 1} then {0x80000000, inf = 1}.
- Backpressure: hold `res_ready` = 0 and offer 20 ops continuously. Required: exactly 16 accepted, `op_ready` = 0 from the 17th offer, `outstanding` = 16. Then pop one; `op_ready` = 1 in the following cycle, not the pop cycle.
- Streaming: issue and pop every cycle for 100 ops with random operands. Required: results match a reference model in order, `credits` stays constant after fill, `err` stays 0.
- Reset mid-flight: issue 3 ops, assert `reset` for one cycle two cycles later. Required: `res_valid` stays 0 throughout, stale `add_done` pulses are ignored, `err` = 0, and `op_ready` returns 9 cycles after reset deassertion.
- Spurious done: in RUN with `inflight` = 0, force `add_done` = 1 for one cycle. Required: the FIFO is unchanged and `err` = 1 from the next cycle until reset.
